// File: rtl/spi_pkg.sv
// Shared definitions for the SPI register controller: FSM encoding, command
// byte layout, address width and parameter defaults.
package spi_pkg;

  localparam int unsigned ADDR_W     = 4;
  localparam int unsigned NUM_REGS   = 16;
  localparam int unsigned CMD_WR_BIT = 7;

  localparam logic [7:0] ID_VALUE_DEF  = 8'hA5;
  localparam logic [7:0] SYNC_BYTE_DEF = 8'h5A;

  // Highest register address; read-only ID register.
  localparam logic [ADDR_W-1:0] ID_ADDR = ADDR_W'(NUM_REGS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CMD   = 2'd1,
    ST_WRITE = 2'd2,
    ST_READ  = 2'd3
  } state_e;

  // Register address auto-increment, wraps naturally at ADDR_W bits.
  function automatic logic [ADDR_W-1:0] addr_next(input logic [ADDR_W-1:0] a);
    return a + ADDR_W'(1);
  endfunction

endpackage

// File: rtl/spi_cs_sync.sv
// Chip-select synchroniser: two-flop synchroniser for the raw CSn pad with
// registered falling/rising edge pulses aligned to the csn_s transition.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   csn_pad    - raw chip select (async)
//   csn_s      - synchronised chip select
//   csn_fall   - one-cycle pulse, csn_s just went low
//   csn_rise   - one-cycle pulse, csn_s just went high
module spi_cs_sync (
  input  logic clk,
  input  logic rst,
  input  logic csn_pad,
  output logic csn_s,
  output logic csn_fall,
  output logic csn_rise
);

  logic sync1_q;
  logic sync2_q;
  logic fall_q;
  logic rise_q;
  logic vld_q;
  logic armed_q;

  // Falling edges are only honoured once the pad has been seen high after
  // reset, so a CSn held low through reset cannot start a transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      fall_q  <= 1'b0;
      rise_q  <= 1'b0;
      vld_q   <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      sync1_q <= csn_pad;
      sync2_q <= sync1_q;
      vld_q   <= 1'b1;
      armed_q <= armed_q | (vld_q & sync1_q);
      fall_q  <= armed_q & sync2_q & ~sync1_q;
      rise_q  <= ~sync2_q & sync1_q;
    end
  end

  assign csn_s    = sync2_q;
  assign csn_fall = fall_q;
  assign csn_rise = rise_q;

endmodule

// File: rtl/spi_reg_ctrl.sv
// SPI slave register controller. A transaction starts on CSn falling, the
// first byte is a command (bit 7 = write, bits 3:0 = start address), and
// following bytes write or read consecutive registers with wrapping address.
// Ports:
//   sys_clk, rst        - clock, synchronous active-high reset
//   csn_pad             - raw SPI chip select, active low
//   spi_dreq/data_rx    - received byte strobe and data from the peripheral
//   spi_data_to_send    - next MISO byte, spi_data_written pulses on update
//   usr_addr/usr_rdata  - combinational fabric read port
//   wr_strobe/addr/data - per-register SPI write notification
module spi_reg_ctrl
  import spi_pkg::*;
#(
  parameter int unsigned       BYTE_W    = 8,
  parameter logic [BYTE_W-1:0] ID_VALUE  = BYTE_W'(ID_VALUE_DEF),
  parameter logic [BYTE_W-1:0] SYNC_BYTE = BYTE_W'(SYNC_BYTE_DEF)
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic              csn_pad,
  input  logic              spi_dreq,
  input  logic [BYTE_W-1:0] spi_data_rx,
  output logic [BYTE_W-1:0] spi_data_to_send,
  output logic              spi_data_written,
  input  logic [ADDR_W-1:0] usr_addr,
  output logic [BYTE_W-1:0] usr_rdata,
  output logic              wr_strobe,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [BYTE_W-1:0] wr_data
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [BYTE_W-1:0]   regs_q [NUM_REGS];
  logic [BYTE_W-1:0]   to_send_q, to_send_d;
  logic                written_q, written_d;
  logic                wr_strobe_q, wr_strobe_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [BYTE_W-1:0]   wr_data_q, wr_data_d;
  logic                reg_we_c;

  logic                csn_s;
  logic                csn_fall;
  logic                csn_rise;
  logic                dreq_ok_c;
  logic                cmd_is_wr_c;
  logic [ADDR_W-1:0]   cmd_addr_c;
  logic [ADDR_W-1:0]   rd_addr_c;
  logic [BYTE_W-1:0]   rd_data_c;

  spi_cs_sync u_cs_sync (
    .clk      (sys_clk),
    .rst      (rst),
    .csn_pad  (csn_pad),
    .csn_s    (csn_s),
    .csn_fall (csn_fall),
    .csn_rise (csn_rise)
  );

  // A byte counts only while selected and never right after an update,
  // which keeps spi_data_written / wr_strobe from pulsing back to back.
  assign dreq_ok_c   = spi_dreq & ~csn_s & ~written_q;
  assign cmd_is_wr_c = spi_data_rx[CMD_WR_BIT];
  assign cmd_addr_c  = spi_data_rx[ADDR_W-1:0];

  // SPI read port: the command byte supplies the address directly.
  always_comb begin
    rd_addr_c = (state_q == ST_CMD) ? cmd_addr_c : addr_q;
    rd_data_c = (rd_addr_c == ID_ADDR) ? ID_VALUE : regs_q[rd_addr_c];
  end

  // Fabric read port.
  always_comb begin
    usr_rdata = (usr_addr == ID_ADDR) ? ID_VALUE : regs_q[usr_addr];
  end

  // State register.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; CSn release wins over everything, including a byte.
  always_comb begin
    state_d = state_q;
    if (csn_rise) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE:  if (csn_fall)  state_d = ST_CMD;
        ST_CMD:   if (dreq_ok_c) state_d = cmd_is_wr_c ? ST_WRITE : ST_READ;
        ST_WRITE: state_d = ST_WRITE;
        ST_READ:  state_d = ST_READ;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // Output / datapath next values.
  always_comb begin
    addr_d      = addr_q;
    to_send_d   = to_send_q;
    written_d   = 1'b0;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    reg_we_c    = 1'b0;
    if (!csn_rise) begin
      unique case (state_q)
        ST_IDLE: begin
          if (csn_fall) begin
            to_send_d = SYNC_BYTE;
            written_d = 1'b1;
          end
        end
        ST_CMD: begin
          if (dreq_ok_c) begin
            written_d = 1'b1;
            if (cmd_is_wr_c) begin
              addr_d    = cmd_addr_c;
              to_send_d = '0;
            end else begin
              addr_d    = addr_next(cmd_addr_c);
              to_send_d = rd_data_c;
            end
          end
        end
        ST_WRITE: begin
          if (dreq_ok_c) begin
            reg_we_c    = (addr_q != ID_ADDR);
            wr_strobe_d = 1'b1;
            wr_addr_d   = addr_q;
            wr_data_d   = spi_data_rx;
            addr_d      = addr_next(addr_q);
            to_send_d   = '0;
            written_d   = 1'b1;
          end
        end
        ST_READ: begin
          if (dreq_ok_c) begin
            to_send_d = rd_data_c;
            written_d = 1'b1;
            addr_d    = addr_next(addr_q);
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath and output registers.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      addr_q      <= '0;
      to_send_q   <= '0;
      written_q   <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      addr_q      <= addr_d;
      to_send_q   <= to_send_d;
      written_q   <= written_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      if (reg_we_c) begin
        regs_q[addr_q] <= spi_data_rx;
      end
    end
  end

  assign spi_data_to_send = to_send_q;
  assign spi_data_written = written_q;
  assign wr_strobe        = wr_strobe_q;
  assign wr_addr          = wr_addr_q;
  assign wr_data          = wr_data_q;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Testbench for spi_reg_ctrl: directed scenarios plus randomized transactions
// checked against a transaction-level model of the register file.
module tb_spi_reg_ctrl;

  logic       sys_clk = 1'b0;
  logic       rst;
  logic       csn_pad;
  logic       spi_dreq;
  logic [7:0] spi_data_rx;
  logic [7:0] spi_data_to_send;
  logic       spi_data_written;
  logic [3:0] usr_addr;
  logic [7:0] usr_rdata;
  logic       wr_strobe;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;

  spi_reg_ctrl dut (
    .sys_clk          (sys_clk),
    .rst              (rst),
    .csn_pad          (csn_pad),
    .spi_dreq         (spi_dreq),
    .spi_data_rx      (spi_data_rx),
    .spi_data_to_send (spi_data_to_send),
    .spi_data_written (spi_data_written),
    .usr_addr         (usr_addr),
    .usr_rdata        (usr_rdata),
    .wr_strobe        (wr_strobe),
    .wr_addr          (wr_addr),
    .wr_data          (wr_data)
  );

  always #5 sys_clk = ~sys_clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Transaction-level model: register contents plus the current transaction's
  // command and byte index.
  logic [7:0] m_regs [16];
  bit         m_active;
  bit         m_is_wr;
  logic [3:0] m_cmd_addr;
  int         m_idx;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] m_rd(input logic [3:0] a);
    return (a == 4'hF) ? 8'hA5 : m_regs[a];
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
    m_active = 1'b0;
    m_idx    = 0;
  endtask

  task automatic check_quiet(input string tag, input int n);
    repeat (n) begin
      @(negedge sys_clk);
      chk({tag, "_written"}, 32'(spi_data_written), 32'd0);
      chk({tag, "_strobe"}, 32'(wr_strobe), 32'd0);
    end
  endtask

  task automatic sweep(input string tag);
    for (int a = 0; a < 16; a++) begin
      @(negedge sys_clk);
      usr_addr = 4'(a);
      #1;
      chk($sformatf("%s_rd%0d", tag, a), 32'(usr_rdata), 32'(m_rd(4'(a))));
    end
  endtask

  // Drop CSn and expect exactly one SYNC update.
  task automatic cs_start();
    int         pulses;
    logic [7:0] seen;
    pulses = 0;
    seen   = 8'h00;
    @(negedge sys_clk);
    csn_pad = 1'b0;
    repeat (6) begin
      @(negedge sys_clk);
      if (spi_data_written) begin
        pulses++;
        seen = spi_data_to_send;
      end
    end
    chk("sync_pulses", 32'(pulses), 32'd1);
    chk("sync_byte", 32'(seen), 32'h5A);
    m_active = 1'b1;
    m_idx    = 0;
  endtask

  task automatic cs_end();
    @(negedge sys_clk);
    csn_pad = 1'b1;
    check_quiet("cs_end", 4);
    m_active = 1'b0;
  endtask

  // Deliver one received byte and check the response one cycle later.
  task automatic spi_byte(input logic [7:0] rx, input string tag);
    bit         exp_wr;
    bit         exp_stb;
    logic [7:0] exp_tx;
    logic [3:0] a;
    exp_wr  = 1'b0;
    exp_stb = 1'b0;
    exp_tx  = 8'h00;
    a       = 4'h0;
    if (m_active) begin
      exp_wr = 1'b1;
      if (m_idx == 0) begin
        m_cmd_addr = rx[3:0];
        m_is_wr    = rx[7];
        exp_tx     = m_is_wr ? 8'h00 : m_rd(rx[3:0]);
      end else if (m_is_wr) begin
        a       = m_cmd_addr + 4'(m_idx - 1);
        exp_stb = 1'b1;
        if (a != 4'hF) m_regs[a] = rx;
      end else begin
        a      = m_cmd_addr + 4'(m_idx);
        exp_tx = m_rd(a);
      end
      m_idx++;
    end
    @(negedge sys_clk);
    usr_addr    = a;
    spi_dreq    = 1'b1;
    spi_data_rx = rx;
    @(negedge sys_clk);
    spi_dreq    = 1'b0;
    spi_data_rx = 8'($urandom);
    chk({tag, "_written"}, 32'(spi_data_written), 32'(exp_wr));
    chk({tag, "_strobe"}, 32'(wr_strobe), 32'(exp_stb));
    if (exp_wr) chk({tag, "_tx"}, 32'(spi_data_to_send), 32'(exp_tx));
    if (exp_stb) begin
      chk({tag, "_waddr"}, 32'(wr_addr), 32'(a));
      chk({tag, "_wdata"}, 32'(wr_data), 32'(rx));
      chk({tag, "_rdback"}, 32'(usr_rdata), 32'(m_rd(a)));
    end
    check_quiet({tag, "_gap"}, 1 + int'($urandom_range(0, 2)));
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] cmd;
    int         nb;
    rst         = 1'b1;
    csn_pad     = 1'b1;
    spi_dreq    = 1'b0;
    spi_data_rx = 8'h00;
    usr_addr    = 4'h0;
    m_reset();

    // Reset state
    repeat (3) @(negedge sys_clk);
    chk("rst_written", 32'(spi_data_written), 32'd0);
    chk("rst_strobe", 32'(wr_strobe), 32'd0);
    chk("rst_tx", 32'(spi_data_to_send), 32'd0);
    chk("rst_waddr", 32'(wr_addr), 32'd0);
    chk("rst_wdata", 32'(wr_data), 32'd0);
    sweep("rst");
    @(negedge sys_clk);
    rst = 1'b0;
    check_quiet("post_rst", 4);

    // Select with no bytes: one SYNC update only
    cs_start();
    cs_end();

    // Write 0x11, 0x22 to regs 3, 4
    cs_start();
    spi_byte(8'h83, "w_cmd");
    spi_byte(8'h11, "w_b1");
    spi_byte(8'h22, "w_b2");
    cs_end();
    sweep("after_w");

    // Read back from reg 3
    cs_start();
    spi_byte(8'h03, "r_cmd");
    spi_byte(8'h00, "r_b1");
    spi_byte(8'h00, "r_b2");
    cs_end();

    // Write across the ID register and wrap to 0
    cs_start();
    spi_byte(8'h8E, "wrap_cmd");
    spi_byte(8'hAA, "wrap_b1");
    spi_byte(8'hBB, "wrap_b2");
    spi_byte(8'hCC, "wrap_b3");
    cs_end();
    sweep("after_wrap");

    // CSn release coincident with a write byte is ignored
    cs_start();
    spi_byte(8'h82, "cr_cmd");
    spi_byte(8'h44, "cr_b1");
    @(negedge sys_clk);
    csn_pad = 1'b1;
    @(posedge sys_clk);
    @(posedge sys_clk);
    @(negedge sys_clk);
    usr_addr    = 4'h3;
    spi_dreq    = 1'b1;
    spi_data_rx = 8'h55;
    @(negedge sys_clk);
    spi_dreq = 1'b0;
    chk("cr_written", 32'(spi_data_written), 32'd0);
    chk("cr_strobe", 32'(wr_strobe), 32'd0);
    chk("cr_reg3", 32'(usr_rdata), 32'(m_rd(4'h3)));
    m_active = 1'b0;
    check_quiet("cr_after", 3);
    spi_byte(8'h91, "idle_byte");
    sweep("after_cr");

    // Reset in the middle of a transaction
    cs_start();
    spi_byte(8'h85, "ra_cmd");
    @(negedge sys_clk);
    rst = 1'b1;
    repeat (2) @(negedge sys_clk);
    chk("ra_written", 32'(spi_data_written), 32'd0);
    chk("ra_tx", 32'(spi_data_to_send), 32'd0);
    rst = 1'b0;
    m_reset();
    sweep("ra_cleared");
    spi_byte(8'h77, "ra_nocs");
    spi_byte(8'h66, "ra_nocs2");
    sweep("ra_still");
    cs_end();

    // Randomized transactions
    for (int t = 0; t < 24; t++) begin
      if ($urandom_range(0, 3) == 0) spi_byte(8'($urandom), "rnd_idle");
      cs_start();
      cmd = 8'($urandom);
      nb  = int'($urandom_range(0, 6));
      spi_byte(cmd, "rnd_cmd");
      for (int b = 0; b < nb; b++) spi_byte(8'($urandom), "rnd_data");
      cs_end();
      if (t % 4 == 3) sweep("rnd");
    end
    sweep("final");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_reg_ctrl.md
SPI_REG_CTRL -- requirements
Module: spi_reg_ctrl

Interface
REQ-001 SHALL have parameter BYTE_W, default 8, SPI byte width.
REQ-002 SHALL have parameter ID_VALUE, default 8'hA5, read-only value of register 15.
REQ-003 SHALL have parameter SYNC_BYTE, default 8'h5A, byte shifted out during the command byte.
REQ-004 sys_clk  in  1  single clock; all logic on its rising edge.
REQ-005 rst  in  1  reset, synchronous and active-high.
REQ-006 csn_pad  in  1  raw SPI chip select, active low, asynchronous to sys_clk.
REQ-007 spi_dreq  in  1  one-cycle pulse from the SPI byte peripheral: byte received.
REQ-008 spi_data_rx  in  BYTE_W  received byte, valid when spi_dreq=1.
REQ-009 spi_data_to_send  out  BYTE_W  next byte for the peripheral to shift out on MISO.
REQ-010 spi_data_written  out  1  one-cycle pulse: spi_data_to_send has been updated.
REQ-011 usr_addr  in  4  fabric read address.
REQ-012 usr_rdata  out  BYTE_W  combinational read of regs[usr_addr].
REQ-013 wr_strobe  out  1  one-cycle pulse per register written over SPI.
REQ-014 wr_addr / wr_data  out  4 / BYTE_W  address and data of that write, valid with wr_strobe.

Function
REQ-015 SHALL synchronise csn_pad through two flops (csn_s); all decisions use csn_s.
REQ-016 SHALL hold a 16 x BYTE_W register file; register 15 reads ID_VALUE and ignores writes.
REQ-017 FSM states: IDLE, CMD, WRITE, READ.
REQ-018 IDLE: on csn_s falling edge -> CMD; next cycle spi_data_to_send=SYNC_BYTE, spi_data_written=1 for one cycle.
REQ-019 CMD: on spi_dreq, latch addr=spi_data_rx[3:0]; bit7=1 -> WRITE, bit7=0 -> READ; bits[6:4] ignored.
REQ-020 CMD->READ: the cycle after spi_dreq, spi_data_to_send=regs[addr], spi_data_written pulses, addr<=addr+1.
REQ-021 READ: each spi_dreq loads regs[addr] into spi_data_to_send the following cycle, pulses spi_data_written, increments addr; the received byte is discarded.
REQ-022 WRITE: each spi_dreq writes spi_data_rx to regs[addr], pulses wr_strobe/wr_addr/wr_data the following cycle, increments addr; spi_data_to_send=8'h00 with a spi_data_written pulse.
REQ-023 addr is 4-bit and SHALL wrap 15 -> 0.
REQ-024 A write to addr 15 SHALL still pulse wr_strobe with wr_addr=15, but leave the register file unchanged.
REQ-025 csn_s rising edge in any state -> IDLE the next cycle; spi_dreq in the same cycle as that edge SHALL be ignored (no write, no load).
REQ-026 spi_dreq while in IDLE SHALL be ignored.
REQ-027 spi_data_written and wr_strobe SHALL never be high for two consecutive cycles.
REQ-028 SPI latency: spi_dreq -> spi_data_written / wr_strobe is exactly 1 sys_clk.
REQ-029 usr_rdata reflects an SPI write in the cycle after the write's spi_dreq.

Reset
REQ-030 While rst=1: state=IDLE, addr=0, regs 0-14 = 0, spi_data_to_send=0, spi_data_written=0, wr_strobe=0, wr_addr=0, wr_data=0, both csn_s flops=1.
REQ-031 rst asserted mid-transaction SHALL abort it; after release, the block waits for a fresh csn_s falling edge.

Structure
REQ-032 Shared package spi_pkg: FSM state encoding, command bit position (7), address width (4), ID_VALUE and SYNC_BYTE defaults.
REQ-033 One sub-module, spi_cs_sync: 2-flop synchroniser with registered fall/rise edge pulses.

Verification
REQ-034 Reset, then csn low, no SCK -> spi_data_to_send=8'h5A, exactly one spi_data_written pulse.
REQ-035 Bytes 8'h83, 8'h11, 8'h22 -> regs[3]=8'h11, regs[4]=8'h22; two wr_strobe pulses with addr 3, 4.
REQ-036 After REQ-035, bytes 8'h03, 8'h00, 8'h00 -> MISO bytes 2 and 3 = 8'h11, 8'h22.
REQ-037 Bytes 8'h8E, 8'hAA, 8'hBB, 8'hCC -> regs[14]=8'hAA, reg15 still reads 8'hA5, regs[0]=8'hCC (wrap).
REQ-038 csn rise coincident with spi_dreq carrying a write -> no register change, no wr_strobe, state IDLE.
REQ-039 rst pulse after CMD byte 8'h85 -> state IDLE, regs cleared; next byte without a new csn edge causes no write.
